edit_step_controller: RTL and testbench
=======================================

Name: edit_step_controller

Overview:
- Sits directly downstream of the user-interface stage and consumes its click, speed and cursor outputs.
- Converts the speed setting into generation-step requests for the life engine, using a phase accumulator and a start/done handshake.
- Converts click presses into read-modify-write toggles of the addressed cell in board memory.
- Owns board-memory access whenever the engine is idle.

Parameters:
- ACC_WIDTH, 24, phase-accumulator width. Step rate = speed_in * f_clk / 2**ACC_WIDTH.
- READ_LATENCY, 2, board-memory read latency in cycles (1..3).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- click_in  input  1  debounced click level
- speed_in  input  LOG_MAX_SPEED  step-rate setting; 0 = paused
- cursor_x_in  input  LOG_BOARD_SIZE  cursor column
- cursor_y_in  input  LOG_BOARD_SIZE  cursor row
- single_step_in  input  1  one-step request pulse; used only with the optional feature
- logic_done_in  input  1  engine pulse: generation complete
- step_start_out  output  1  one-cycle pulse that starts one generation
- busy_out  output  1  engine generation in progress
- mem_sel_out  output  1  1 = this block drives board memory; 0 = engine owns it
- mem_addr_out  output  2*LOG_BOARD_SIZE  cell address {y,x}
- mem_we_out  output  1  write enable
- mem_wdata_out  output  1  cell write data
- mem_rdata_in  input  1  cell read data
- edit_done_out  output  1  one-cycle pulse when a toggle write is issued

Behaviour:
- Reset (synchronous, active-high; takes effect mid-operation too):
  - state=IDLE; acc=0; both pending flags=0; click_q=0.
  - All outputs 0, except mem_sel_out=1.
  - An in-flight step is abandoned. A later logic_done_in is ignored in IDLE.
- Click edge detection:
  - click_q <= click_in every cycle.
  - A rising edge (click_in & !click_q) sets edit_pending and latches {cursor_y_in, cursor_x_in} into edit_addr.
  - A rising edge while edit_pending=1 is dropped; the address is not overwritten.
- Accumulator:
  - {carry, acc} = acc + speed_in, zero-extended to ACC_WIDTH+1 bits, every cycle in every state.
  - carry=1 sets step_pending. A carry while step_pending=1 is dropped (one-deep queue).
  - speed_in=0 never produces a carry; acc holds its value.
- FSM states: IDLE, RD_WAIT, WRITE, STEP_BUSY.
  - IDLE:
    - If edit_pending: mem_addr_out=edit_addr, go to RD_WAIT, load the wait counter with READ_LATENCY-1.
    - Else if step_pending: step_start_out=1 for this cycle, clear step_pending, mem_sel_out<=0, go to STEP_BUSY.
    - Edit has priority over step when both are pending in the same cycle.
  - RD_WAIT: hold mem_addr_out; count down. At 0, go to WRITE. mem_rdata_in is valid READ_LATENCY cycles after the address was presented.
  - WRITE (one cycle):
    - mem_we_out=1, mem_wdata_out=~mem_rdata_in, edit_done_out=1.
    - Clear edit_pending, return to IDLE.
    - A click edge arriving in this same cycle is accepted as a new pending edit; the new edge wins over the clear.
  - STEP_BUSY:
    - busy_out=1, mem_sel_out=0, mem_we_out=0.
    - On logic_done_in: mem_sel_out<=1, go to IDLE.
    - Clicks and accumulator carries are still queued while busy.
- Latency:
  - Click edge to write: 2+READ_LATENCY cycles (4 at default), when idle.
  - Carry to step_start_out: 1 cycle, when idle with no edit pending.
- mem_we_out is asserted only in WRITE.
- mem_addr_out is don't-care while mem_sel_out=0; it is driven to 0 there.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined: a single_step_in pulse while speed_in==0 sets step_pending, with the same one-deep drop rule. The pulse is ignored when speed_in!=0.
- Undefined: single_step_in is unused and has no effect. The port remains present so the top level is unchanged.

Decomposition:
- Shared package (existing common header): LOG_BOARD_SIZE, BOARD_SIZE, LOG_MAX_SPEED, and a cell_addr_t typedef (2*LOG_BOARD_SIZE bits, {y,x}).
- The FSM state enum stays local to this module.
- One natural sub-module: rate_accumulator (acc + speed, carry pulse out), reusable for other timing.

Test Plan:
- Reset, then click rising edge with cursor (5,7) and memory cell=0:
  - mem_we_out high exactly 4 cycles after the edge, addr={7,5}, wdata=1, edit_done_out pulses.
  - A second click on the same cell writes 0.
- ACC_WIDTH=4, speed_in=4, logic_done_in returned 3 cycles after each start:
  - step_start_out pulses every 4 cycles.
  - busy_out high between each start and its done.
  - mem_sel_out is the inverse of busy_out.
- speed_in=0 for 1000 cycles: no step_start_out; acc unchanged.
- Click edge and carry in the same idle cycle:
  - Edit write completes first.
  - step_start_out fires in the cycle after WRITE.
- Three click edges while STEP_BUSY, logic_done_in held off 50 cycles:
  - Exactly one write, to the first latched address, after done.
  - Extra carries during busy yield only one subsequent step.
- rst_in asserted during RD_WAIT and during STEP_BUSY:
  - Next cycle: IDLE, all outputs 0 except mem_sel_out=1, no write.
  - A late logic_done_in is ignored.
- With SINGLE_STEP_EN, speed_in=0: single_step_in pulse gives exactly one step_start_out.
- Without SINGLE_STEP_EN, same stimulus: no step_start_out.

Source files
------------

// File: rtl/edit_step_controller_pkg.sv
// Shared board/speed definitions used by the edit/step controller and its
// neighbours in the UI -> controller -> life-engine chain.
//   LOG_BOARD_SIZE : bits per cursor coordinate
//   BOARD_SIZE     : cells per board row/column
//   LOG_MAX_SPEED  : width of the step-rate setting
//   cell_addr_t    : board-memory cell address, packed as {y, x}
package edit_step_controller_pkg;

  localparam int LOG_BOARD_SIZE = 6;
  localparam int BOARD_SIZE     = 1 << LOG_BOARD_SIZE;
  localparam int LOG_MAX_SPEED  = 4;

  typedef logic [2*LOG_BOARD_SIZE-1:0] cell_addr_t;

  function automatic cell_addr_t make_cell_addr(input logic [LOG_BOARD_SIZE-1:0] y,
                                                input logic [LOG_BOARD_SIZE-1:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/edit_step_controller_rate_accumulator.sv
// Phase accumulator: adds speed_in to an ACC_WIDTH-bit accumulator every
// cycle and reports the overflow as a one-cycle carry pulse. Output rate is
// speed_in * f_clk / 2**ACC_WIDTH; speed_in = 0 holds the phase.
// Ports:
//   clk_in    : clock
//   rst_in    : synchronous active-high reset, clears the phase
//   speed_in  : increment per cycle
//   carry_out : high in the cycle whose addition overflows the accumulator
module edit_step_controller_rate_accumulator #(
  parameter int ACC_WIDTH   = 24,
  parameter int SPEED_WIDTH = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [SPEED_WIDTH-1:0] speed_in,
  output logic                   carry_out
);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   sum;

  always_comb sum = {1'b0, acc} + (ACC_WIDTH+1)'(speed_in);

  always_ff @(posedge clk_in) begin
    if (rst_in) acc <= '0;
    else        acc <= sum[ACC_WIDTH-1:0];
  end

  assign carry_out = sum[ACC_WIDTH];

endmodule

// File: rtl/edit_step_controller.sv
// Edit/step controller. Turns the UI speed setting into generation-step
// requests for the life engine (start/done handshake) and click presses into
// read-modify-write toggles of the cursor cell in board memory. Owns board
// memory whenever the engine is idle.
// Build option: define SINGLE_STEP_EN to let single_step_in request one step
// while paused (speed_in == 0); otherwise single_step_in is ignored.
// Ports:
//   clk_in, rst_in          : clock, synchronous active-high reset
//   click_in                : debounced click level (rising edge = toggle)
//   speed_in                : step-rate setting, 0 = paused
//   cursor_x_in/cursor_y_in : cursor cell
//   single_step_in          : one-step request pulse (SINGLE_STEP_EN only)
//   logic_done_in           : engine finished the current generation
//   step_start_out          : one-cycle pulse starting a generation
//   busy_out                : generation in progress
//   mem_sel_out             : 1 = this block drives board memory
//   mem_addr_out/we/wdata   : board-memory write port, address {y,x}
//   mem_rdata_in            : board-memory read data, READ_LATENCY cycles late
//   edit_done_out           : one-cycle pulse when a toggle write is issued
//
// state     | meaning
// IDLE      | memory owned here; launch pending edit, else pending step
// RD_WAIT   | address held, counting down the memory read latency
// WRITE     | write inverted cell value, single cycle
// STEP_BUSY | engine owns memory until logic_done_in
module edit_step_controller
  import edit_step_controller_pkg::*;
#(
  parameter int ACC_WIDTH    = 24,
  parameter int READ_LATENCY = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      click_in,
  input  logic [LOG_MAX_SPEED-1:0]  speed_in,
  input  logic [LOG_BOARD_SIZE-1:0] cursor_x_in,
  input  logic [LOG_BOARD_SIZE-1:0] cursor_y_in,
  input  logic                      single_step_in,
  input  logic                      logic_done_in,
  output logic                      step_start_out,
  output logic                      busy_out,
  output logic                      mem_sel_out,
  output cell_addr_t                mem_addr_out,
  output logic                      mem_we_out,
  output logic                      mem_wdata_out,
  input  logic                      mem_rdata_in,
  output logic                      edit_done_out
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, STEP_BUSY} state_t;

  state_t     state, state_n;
  logic [1:0] wait_cnt, wait_cnt_n;
  logic       mem_sel, mem_sel_n;
  logic       click_q, click_rise;
  logic       edit_pending, edit_clr;
  cell_addr_t edit_addr;
  logic       step_pending, step_clr, step_req;
  logic       carry;

  edit_step_controller_rate_accumulator #(
    .ACC_WIDTH  (ACC_WIDTH),
    .SPEED_WIDTH(LOG_MAX_SPEED)
  ) u_rate_acc (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .speed_in (speed_in),
    .carry_out(carry)
  );

  assign click_rise = click_in & ~click_q;

`ifdef SINGLE_STEP_EN
  assign step_req = carry | (single_step_in & (speed_in == '0));
`else
  logic unused_single_step;
  assign unused_single_step = single_step_in;
  assign step_req = carry;
`endif

  always_comb begin
    state_n        = state;
    wait_cnt_n     = wait_cnt;
    mem_sel_n      = mem_sel;
    edit_clr       = 1'b0;
    step_clr       = 1'b0;
    step_start_out = 1'b0;
    busy_out       = 1'b0;
    mem_addr_out   = '0;
    mem_we_out     = 1'b0;
    mem_wdata_out  = 1'b0;
    edit_done_out  = 1'b0;
    case (state)
      IDLE: begin
        if (edit_pending) begin
          mem_addr_out = edit_addr;
          wait_cnt_n   = 2'(READ_LATENCY - 1);
          state_n      = RD_WAIT;
        end else if (step_pending) begin
          step_start_out = 1'b1;
          step_clr       = 1'b1;
          mem_sel_n      = 1'b0;
          state_n        = STEP_BUSY;
        end
      end
      RD_WAIT: begin
        mem_addr_out = edit_addr;
        if (wait_cnt == 2'd0) state_n = WRITE;
        else                  wait_cnt_n = wait_cnt - 2'd1;
      end
      WRITE: begin
        mem_addr_out  = edit_addr;
        mem_we_out    = 1'b1;
        mem_wdata_out = ~mem_rdata_in;
        edit_done_out = 1'b1;
        edit_clr      = 1'b1;
        state_n       = IDLE;
      end
      STEP_BUSY: begin
        busy_out = 1'b1;
        if (logic_done_in) begin
          mem_sel_n = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      mem_sel      <= 1'b1;
      click_q      <= 1'b0;
      edit_pending <= 1'b0;
      edit_addr    <= '0;
      step_pending <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      mem_sel  <= mem_sel_n;
      click_q  <= click_in;
      // A fresh edge in the WRITE cycle replaces the edit being retired.
      if (click_rise && (!edit_pending || edit_clr)) begin
        edit_pending <= 1'b1;
        edit_addr    <= make_cell_addr(cursor_y_in, cursor_x_in);
      end else if (edit_clr) begin
        edit_pending <= 1'b0;
      end
      // A request landing on the launch cycle stays queued for the next step.
      if (step_req)      step_pending <= 1'b1;
      else if (step_clr) step_pending <= 1'b0;
    end
  end

  assign mem_sel_out = mem_sel;

endmodule

// File: tb/tb_edit_step_controller.sv
module tb_edit_step_controller;
  import edit_step_controller_pkg::*;

  localparam int ACC_W = 4;
  localparam int RL    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1, click = 1'b0, single_step = 1'b0, done = 1'b0;
  logic [LOG_MAX_SPEED-1:0]  speed = '0;
  logic [LOG_BOARD_SIZE-1:0] cur_x = '0, cur_y = '0;
  logic step_start, busy, mem_sel, mem_we, mem_wdata, mem_rdata, edit_done;
  cell_addr_t mem_addr;

  logic [BOARD_SIZE*BOARD_SIZE-1:0] mem = '0;
  logic [BOARD_SIZE*BOARD_SIZE-1:0] shadow = '0;
  logic [RL-1:0] rd_pipe = '0;
  int cyc = 0;
  int n_checks = 0, n_pass = 0;

  typedef struct {cell_addr_t addr; logic data;} wr_t;
  wr_t exp_wr[$];
  int  exp_start[$];

  edit_step_controller #(.ACC_WIDTH(ACC_W), .READ_LATENCY(RL)) dut (
    .clk_in(clk), .rst_in(rst), .click_in(click), .speed_in(speed),
    .cursor_x_in(cur_x), .cursor_y_in(cur_y), .single_step_in(single_step),
    .logic_done_in(done), .step_start_out(step_start), .busy_out(busy),
    .mem_sel_out(mem_sel), .mem_addr_out(mem_addr), .mem_we_out(mem_we),
    .mem_wdata_out(mem_wdata), .mem_rdata_in(mem_rdata), .edit_done_out(edit_done)
  );

  always #5 clk = ~clk;

  // Board memory with two-cycle read latency.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_pipe <= {rd_pipe[0], mem[mem_addr]};
    if (mem_sel && mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = rd_pipe[RL-1];

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; click = 1'b0; done = 1'b0; single_step = 1'b0; speed = '0;
    next();
    rst = 1'b0;
    exp_wr.delete();
    exp_start.delete();
  endtask

  task automatic press(input int x, input int y, input bit track);
    cell_addr_t a;
    cur_x = LOG_BOARD_SIZE'(x);
    cur_y = LOG_BOARD_SIZE'(y);
    click = 1'b1;
    if (track) begin
      a = {cur_y, cur_x};
      exp_wr.push_back('{a, ~shadow[a]});
      shadow[a] = ~shadow[a];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({step_start, busy, mem_we, mem_wdata, edit_done} !== 5'b0)
      $display("FAIL reset_outputs: got %b, want 00000", {step_start, busy, mem_we, mem_wdata, edit_done});
    else n_pass++;
    n_checks++;
    if (mem_sel !== 1'b1) $display("FAIL reset_mem_sel: got %b, want 1", mem_sel);
    else n_pass++;
    n_checks++;
    if (mem_addr !== '0) $display("FAIL reset_mem_addr: got %0d, want 0", mem_addr);
    else n_pass++;
    next();
  endtask

  task automatic test_edit();
    int e, lat;
    wr_t w;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      press(5, 7, 1'b1);
      e = cyc; lat = -1;
      for (int i = 0; i < 12 && lat < 0; i++) begin
        @(negedge clk);
        if (mem_we) begin
          lat = cyc - e;
          n_checks++;
          if (exp_wr.size() == 0) $display("FAIL edit_unexpected_write: addr %0d", mem_addr);
          else begin
            w = exp_wr.pop_front();
            if (mem_addr !== w.addr || mem_wdata !== w.data || edit_done !== 1'b1)
              $display("FAIL edit_write%0d: got addr %0d data %b done %b, want addr %0d data %b done 1",
                       k, mem_addr, mem_wdata, edit_done, w.addr, w.data);
            else n_pass++;
          end
        end
        next();
        click = 1'b0;
      end
      n_checks++;
      if (lat != 2 + RL) $display("FAIL edit_latency%0d: got %0d, want %0d", k, lat, 2 + RL);
      else n_pass++;
    end
  endtask

  task automatic test_step_rate();
    int acc_m, done_at, last_start, n_starts, e;
    logic busy_exp;
    do_reset();
    speed = 4; acc_m = 0; done_at = -100; last_start = -100; n_starts = 0;
    for (int i = 0; i < 40; i++) begin
      done = (cyc == done_at);
      if (acc_m + 4 >= (1 << ACC_W)) exp_start.push_back(cyc + 1);
      acc_m = (acc_m + 4) % (1 << ACC_W);
      @(negedge clk);
      if (step_start) begin
        n_starts++;
        n_checks++;
        if (exp_start.size() == 0) $display("FAIL step_unexpected: start at cycle %0d", cyc);
        else begin
          e = exp_start.pop_front();
          if (cyc != e) $display("FAIL step_time: got cycle %0d, want %0d", cyc, e);
          else n_pass++;
          last_start = e;
        end
        done_at = cyc + 3;
      end
      busy_exp = (cyc > last_start) && (cyc <= last_start + 3);
      n_checks++;
      if (busy !== busy_exp) $display("FAIL step_busy: cycle %0d got %b, want %b", cyc, busy, busy_exp);
      else n_pass++;
      n_checks++;
      if (mem_sel !== ~busy_exp) $display("FAIL step_mem_sel: cycle %0d got %b, want %b", cyc, mem_sel, ~busy_exp);
      else n_pass++;
      next();
    end
    done = 1'b0;
    n_checks++;
    if (n_starts != 9) $display("FAIL step_count: got %0d, want 9", n_starts);
    else n_pass++;
  endtask

  task automatic test_pause();
    int starts, t, got;
    do_reset();
    speed = 4;
    next();
    next();
    speed = 0;
    starts = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (step_start) starts++;
      next();
    end
    n_checks++;
    if (starts != 0) $display("FAIL pause_starts: got %0d, want 0", starts);
    else n_pass++;
    speed = 4; t = cyc; got = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (step_start && got < 0) got = cyc - t;
      next();
    end
    n_checks++;
    if (got != 2) $display("FAIL pause_acc_held: start after %0d cycles, want 2", got);
    else n_pass++;
  endtask

  task automatic test_collision();
    int e, wcyc, scyc;
    wr_t w;
    do_reset();
    speed = 4;
    next(); next(); next();
    press(2, 3, 1'b1);
    e = cyc; wcyc = -1; scyc = -1;
    for (int i = 0; i < 15 && (wcyc < 0 || scyc < 0); i++) begin
      @(negedge clk);
      if (mem_we && wcyc < 0) begin
        wcyc = cyc;
        n_checks++;
        w = exp_wr.pop_front();
        if (mem_addr !== w.addr || mem_wdata !== w.data)
          $display("FAIL coll_write: got addr %0d data %b, want addr %0d data %b", mem_addr, mem_wdata, w.addr, w.data);
        else n_pass++;
      end
      if (step_start && scyc < 0) scyc = cyc;
      next();
      click = 1'b0; speed = 0;
    end
    n_checks++;
    if (wcyc - e != 4) $display("FAIL coll_write_latency: got %0d, want 4", wcyc - e);
    else n_pass++;
    n_checks++;
    if (scyc < 0 || scyc - wcyc != 1) $display("FAIL coll_step_after_write: got %0d, want 1", scyc - wcyc);
    else n_pass++;
    done = 1'b1;
    next();
    done = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || mem_sel !== 1'b1)
      $display("FAIL coll_done_release: got busy %b sel %b, want busy 0 sel 1", busy, mem_sel);
    else n_pass++;
    next();
  endtask

  task automatic test_busy_clicks();
    int s, early_wr, early_st, wr_n, st_n, wcyc, scyc;
    wr_t w;
    do_reset();
    speed = 4; s = -1;
    for (int i = 0; i < 10 && s < 0; i++) begin
      @(negedge clk);
      if (step_start) s = cyc;
      next();
    end
    n_checks++;
    if (s < 0) $display("FAIL busy_first_start: got none, want one");
    else n_pass++;
    early_wr = 0; early_st = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10)      press(9, 4, 1'b1);
      else if (i == 20) press(1, 2, 1'b0);
      else if (i == 30) press(3, 3, 1'b0);
      else              click = 1'b0;
      if (i == 40) speed = 0;
      @(negedge clk);
      if (mem_we) early_wr++;
      if (step_start) early_st++;
      next();
    end
    n_checks++;
    if (early_wr != 0 || early_st != 0)
      $display("FAIL busy_hold: got %0d writes %0d starts during busy, want 0 0", early_wr, early_st);
    else n_pass++;
    done = 1'b1;
    next();
    done = 1'b0;
    wr_n = 0; st_n = 0; wcyc = -1; scyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_we) begin
        wr_n++; wcyc = cyc;
        n_checks++;
        if (exp_wr.size() == 0) $display("FAIL busy_extra_write: addr %0d", mem_addr);
        else begin
          w = exp_wr.pop_front();
          if (mem_addr !== w.addr || mem_wdata !== w.data)
            $display("FAIL busy_write: got addr %0d data %b, want addr %0d data %b", mem_addr, mem_wdata, w.addr, w.data);
          else n_pass++;
        end
      end
      if (step_start) begin st_n++; scyc = cyc; end
      next();
    end
    n_checks++;
    if (wr_n != 1) $display("FAIL busy_write_count: got %0d, want 1", wr_n);
    else n_pass++;
    n_checks++;
    if (st_n != 1 || scyc != wcyc + 1)
      $display("FAIL busy_step_count: got %0d starts (at +%0d), want 1 at +1", st_n, scyc - wcyc);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bad, s;
    do_reset();
    cur_x = 6; cur_y = 6; click = 1'b1;
    next();
    click = 1'b0;
    next();
    @(negedge clk);
    n_checks++;
    if (mem_addr !== {6'd6, 6'd6} || mem_we !== 1'b0)
      $display("FAIL rdwait_addr: got addr %0d we %b, want addr %0d we 0", mem_addr, mem_we, {6'd6, 6'd6});
    else n_pass++;
    rst = 1'b1;
    next();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({step_start, busy, mem_sel, mem_we, edit_done} !== 5'b00100 || mem_addr !== '0)
      $display("FAIL rdwait_reset_outputs: got %b addr %0d, want 00100 addr 0",
               {step_start, busy, mem_sel, mem_we, edit_done}, mem_addr);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      next();
      @(negedge clk);
      if (mem_we) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL rdwait_reset_write: got %0d writes, want 0", bad);
    else n_pass++;

    do_reset();
    speed = 4; s = -1;
    for (int i = 0; i < 10 && s < 0; i++) begin
      @(negedge clk);
      if (step_start) s = cyc;
      next();
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL busy_before_reset: got %b, want 1", busy);
    else n_pass++;
    rst = 1'b1;
    next();
    rst = 1'b0; speed = 0;
    @(negedge clk);
    n_checks++;
    if ({step_start, busy, mem_sel, mem_we, edit_done} !== 5'b00100 || mem_addr !== '0)
      $display("FAIL busy_reset_outputs: got %b addr %0d, want 00100 addr 0",
               {step_start, busy, mem_sel, mem_we, edit_done}, mem_addr);
    else n_pass++;
    next();
    done = 1'b1;
    next();
    done = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy || step_start || !mem_sel || mem_we) bad++;
      next();
    end
    n_checks++;
    if (bad != 0) $display("FAIL late_done_ignored: got %0d bad cycles, want 0", bad);
    else n_pass++;
  endtask

  task automatic test_single_step();
    int starts, want;
`ifdef SINGLE_STEP_EN
    want = 1;
`else
    want = 0;
`endif
    do_reset();
    speed = 0;
    single_step = 1'b1;
    next();
    single_step = 1'b0;
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (step_start) starts++;
      next();
    end
    n_checks++;
    if (starts != want) $display("FAIL single_step: got %0d starts, want %0d", starts, want);
    else n_pass++;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_edit();
    test_step_rate();
    test_pause();
    test_collision();
    test_busy_clicks();
    test_reset_mid();
    test_single_step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
